branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- ID-stage controller that sequences conditional-branch resolution in the dynamic pipeline.
- Holds IF/ID while branch operands are pending from forwarding, evaluates the condition on latched operands, then issues a one-cycle redirect/flush or trap request.
- Sits between decode, the forwarding unit, the PC mux and the exception unit.

Parameters:
- DATA_W, 32, operand and PC width
- CNT_W, 16, width of the optional statistics counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID slot holds a valid instruction
- id_branch  in  1  ID instruction is branch-class
- id_branch_type  in  2  00 beq, 01 bne, 10 bgez, 11 teq
- id_pc  in  DATA_W  PC of the ID instruction
- id_offset  in  DATA_W  sign-extended imm16, not yet shifted
- rs_data  in  DATA_W  forwarded rs value
- rt_data  in  DATA_W  forwarded rt value
- rs_ready  in  1  rs value is valid this cycle
- rt_ready  in  1  rt value is valid this cycle
- flush_in  in  1  later-stage exception flush, higher priority
- stall_if_id  out  1  hold PC and IF/ID
- pc_redirect  out  1  one-cycle pulse: load pc_target
- pc_target  out  DATA_W  branch target
- flush_if_id  out  1  one-cycle pulse: squash the IF/ID instruction
- trap_req  out  1  one-cycle pulse: teq condition true
- trap_epc  out  DATA_W  PC of the trapping teq
- branch_done  out  1  one-cycle pulse: resolution complete

Behaviour:
- Reset: state IDLE; all 1-bit outputs 0; pc_target and trap_epc 0; latched registers 0.
- States: IDLE, WAIT, EVAL, DONE.
- Operand readiness: need = rs_ready & (rt_ready | type==10). bgez ignores rt.
- IDLE, when id_valid & id_branch: latch type, pc and offset.
  - need=1: also latch rs/rt, go to EVAL.
  - need=0: go to WAIT.
  - stall_if_id is asserted combinationally in this cycle in both cases.
- WAIT: stall_if_id=1. When need=1, latch rs/rt and go to EVAL. There is no timeout.
- EVAL: stall_if_id=1. Evaluate the condition on the latched operands:
  - beq: rs==rt
  - bne: rs!=rt
  - bgez: signed rs>=0, i.e. rs[31]==0
  - teq: rs==rt
- EVAL always goes to DONE. Pulse outputs are registered on the EVAL->DONE edge.
- DONE: stall_if_id=0 and the pulses are high for exactly this cycle.
  - id_branch is ignored in DONE, because the branch itself leaves ID in this cycle.
  - DONE always goes to IDLE.
- Taken beq/bne/bgez: pc_redirect=1, flush_if_id=1, pc_target = latched_pc + 4 + (offset<<2), modulo 2^DATA_W (wraps silently).
- teq true: trap_req=1, flush_if_id=1, trap_epc=latched_pc, pc_redirect=0.
- Not taken / teq false: only branch_done=1.
- branch_done is 1 in every DONE cycle.
- Latency: operands ready in cycle T (IDLE) -> EVAL at T+1 -> pulses at T+2 -> IDLE at T+3. Each WAIT cycle adds one cycle.
- flush_in in any state:
  - next state is IDLE and no pulses are issued (a pending DONE pulse is suppressed);
  - stall_if_id is forced 0 combinationally;
  - it overrides a new branch in IDLE the same cycle.
- rst has priority over flush_in. Reset mid-operation abandons the branch and issues no pulses.
- Non-branch or id_valid=0 in IDLE: no action, stall_if_id=0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, add outputs taken_cnt, not_taken_cnt and stall_cnt, each CNT_W wide, saturating at all-ones and cleared by rst:
  - taken_cnt: +1 per DONE with a redirect or trap;
  - not_taken_cnt: +1 per DONE otherwise;
  - stall_cnt: +1 per WAIT cycle.
- flush_in-abandoned branches are not counted.
- When undefined, these ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package branch_pkg holds:
  - branch type codes BR_BEQ=2'b00, BR_BNE=2'b01, BR_BGEZ=2'b10, BR_TEQ=2'b11;
  - the FSM state enum;
  - the PC increment constant 4.
- One natural sub-module: branch_cond_eval (combinational type+operands -> cond_true), instantiated on the latched operands.

Test Plan:
- beq, rs=rt=0x5, both ready, id_pc=0x100, offset=0x3 -> stall 1 at T and T+1; at T+2 pc_redirect=1, flush_if_id=1, pc_target=0x110, branch_done=1, stall_if_id=0.
- bne, rs=rt=0x7 -> at T+2 only branch_done=1; pc_redirect=0, flush_if_id=0.
- bgez, rs=0xFFFF_FFFF, rt_ready=0 -> not taken, no WAIT entered. Repeat with rs=0 -> taken.
- beq, rs_ready low for 3 cycles -> 3 WAIT cycles with stall=1, pulses 5 cycles after the branch arrives. With BRANCH_STATS_EN, stall_cnt=3.
- teq equal, id_pc=0x200 -> trap_req=1, trap_epc=0x200, flush_if_id=1, pc_redirect=0. Offset=0xFFFF_FFFF on a beq with id_pc=0 -> pc_target=0x0000_0000 (wrap).
- flush_in asserted during EVAL -> no pulses, stall_if_id=0 that cycle, IDLE next. rst asserted during WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the ID-stage branch resolution controller.
//   - branch type codes as decoded from the instruction
//   - resolution FSM state encoding
//   - PC increment and a helper computing the branch target
package branch_pkg;

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BGEZ = 2'b10;
    localparam logic [1:0] BR_TEQ  = 2'b11;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_EVAL = 2'b10,
        ST_DONE = 2'b11
    } br_state_e;

    // Target = pc + 4 + (offset << 2), modulo 2^32; overflow wraps silently.
    function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [31:0] off);
        return pc + 32'(PC_INC) + {off[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition on latched operands.
//   br_type   in  branch type code (branch_pkg BR_*)
//   rs, rt    in  operand values
//   cond_true out condition holds (taken for beq/bne/bgez, trap for teq)
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (br_type)
            BR_BEQ:  cond_true = (rs == rt);
            BR_BNE:  cond_true = (rs != rt);
            BR_BGEZ: cond_true = ~rs[DATA_W-1];   // signed rs >= 0
            BR_TEQ:  cond_true = (rs == rt);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage conditional-branch resolution controller.
// Holds IF/ID while branch operands are pending from forwarding, evaluates
// the condition on latched operands, then issues a one-cycle redirect/flush
// or trap request together with branch_done.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_*                  ID-slot instruction (valid, branch-class, type, pc, offset)
//   rs_data/rt_data       forwarded operands, qualified by rs_ready/rt_ready
//   flush_in              later-stage exception flush; abandons any branch
//   stall_if_id           hold PC and IF/ID (combinational)
//   pc_redirect/pc_target load branch target into PC (pulse)
//   flush_if_id           squash IF/ID instruction (pulse)
//   trap_req/trap_epc     teq trap request and faulting PC (pulse)
//   branch_done           resolution complete (pulse)
//
// Optional build macro BRANCH_STATS_EN adds saturating counters
// taken_cnt, not_taken_cnt and stall_cnt (CNT_W bits each).
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic [1:0]        id_branch_type,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_offset,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              rs_ready,
    input  logic              rt_ready,
    input  logic              flush_in,
    output logic              stall_if_id,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              trap_req,
    output logic [DATA_W-1:0] trap_epc,
    output logic              branch_done
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    br_state_e         state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] off_q, off_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;
    logic              trap_q, trap_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] epc_q, epc_d;

    logic cond_true;
    logic need_new;   // readiness for the instruction arriving in IDLE
    logic need_lat;   // readiness for the latched (waiting) branch
    logic stall_c;

    assign need_new = rs_ready & (rt_ready | (id_branch_type == BR_BGEZ));
    assign need_lat = rs_ready & (rt_ready | (type_q == BR_BGEZ));

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
        .br_type   (type_q),
        .rs        (rs_q),
        .rt        (rt_q),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        pc_d       = pc_q;
        off_d      = off_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        target_d   = target_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        trap_d     = 1'b0;
        done_d     = 1'b0;
        stall_c    = 1'b0;
        if (flush_in) begin
            // Exception flush wins over everything, including a new branch.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (id_valid && id_branch) begin
                        stall_c = 1'b1;
                        type_d  = id_branch_type;
                        pc_d    = id_pc;
                        off_d   = id_offset;
                        if (need_new) begin
                            rs_d    = rs_data;
                            rt_d    = rt_data;
                            state_d = ST_EVAL;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    stall_c = 1'b1;
                    if (need_lat) begin
                        rs_d    = rs_data;
                        rt_d    = rt_data;
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    stall_c = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (cond_true) begin
                        flush_d = 1'b1;
                        if (type_q == BR_TEQ) begin
                            trap_d = 1'b1;
                            epc_d  = pc_q;
                        end else begin
                            redirect_d = 1'b1;
                            target_d   = br_target(pc_q, off_q);
                        end
                    end
                end
                default: begin
                    // ST_DONE: branch leaves ID this cycle; id_branch ignored.
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            pc_q       <= '0;
            off_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            trap_q     <= 1'b0;
            done_q     <= 1'b0;
            target_q   <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            pc_q       <= pc_d;
            off_q      <= off_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            trap_q     <= trap_d;
            done_q     <= done_d;
            target_q   <= target_d;
            epc_q      <= epc_d;
        end
    end

    // A flush arriving in the DONE cycle suppresses the already-registered pulses.
    assign stall_if_id = stall_c;
    assign pc_redirect = redirect_q & ~flush_in;
    assign flush_if_id = flush_q & ~flush_in;
    assign trap_req    = trap_q & ~flush_in;
    assign branch_done = done_q & ~flush_in;
    assign pc_target   = target_q;
    assign trap_epc    = epc_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        if (!flush_in) begin
            if (state_q == ST_DONE) begin
                if (redirect_q || trap_q) begin
                    if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
                end else begin
                    if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + 1'b1;
                end
            end
            if (state_q == ST_WAIT && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
            stall_cnt_q     <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
    assign stall_cnt     = stall_cnt_q;
`endif

endmodule
